// File: rtl/alu_result_buffer.sv
// Two-entry in-order result buffer between the and/or/xor unit and writeback.
// Zero/sign flags are captured at write so the read side is purely registered.
module alu_result_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_res,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [4:0]       out_rd,
  output logic             out_zero,
  output logic             out_sign,
  input  logic             flush,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] res_r [2];
  logic [4:0]       rd_r  [2];
  logic [1:0]       zero_r;
  logic [1:0]       sign_r;
  logic             wptr_r;
  logic             rptr_r;
  logic [1:0]       count_r;

  logic             full_s;
  logic             push_s;
  logic             pop_s;

  function automatic logic res_is_zero(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b0}});
  endfunction

  // Handshake decode; a full buffer still accepts when the head leaves this cycle.
  always_comb begin
    full_s   = 1'b0;
    in_ready = 1'b0;
    push_s   = 1'b0;
    pop_s    = 1'b0;
    full_s   = (count_r == 2'd2);
    in_ready = flush | ~full_s | out_ready;
    push_s   = in_valid & in_ready & ~flush;
    pop_s    = (count_r != 2'd0) & out_ready & ~flush;
  end

  // Pointer and occupancy state; flush discards everything including same-cycle traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      count_r <= 2'd0;
    end else if (flush) begin
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (push_s) begin
        wptr_r <= ~wptr_r;
      end
      if (pop_s) begin
        rptr_r <= ~rptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry payload; when full with pop-through the write lands in the slot being vacated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r[0] <= {WIDTH{1'b0}};
      res_r[1] <= {WIDTH{1'b0}};
      rd_r[0]  <= 5'd0;
      rd_r[1]  <= 5'd0;
      zero_r   <= 2'b11;
      sign_r   <= 2'b00;
    end else if (push_s) begin
      res_r[wptr_r]  <= in_res;
      rd_r[wptr_r]   <= in_rd;
      zero_r[wptr_r] <= res_is_zero(in_res);
      sign_r[wptr_r] <= in_res[WIDTH-1];
    end
  end

  // Head view is a mux of registers only; nothing from in_* reaches out_*.
  always_comb begin
    out_valid = 1'b0;
    out_valid = (count_r != 2'd0);
    out_res   = res_r[rptr_r];
    out_rd    = rd_r[rptr_r];
    out_zero  = zero_r[rptr_r];
    out_sign  = sign_r[rptr_r];
    count     = count_r;
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed vector table, async-reset
// sequence and a random stream, all checked against a scoreboard queue.
module tb_alu_result_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_res;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_rd;
  logic        out_zero;
  logic        out_sign;
  logic        flush;
  logic [1:0]  count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        zero;
    logic        sign;
  } entry_t;

  typedef struct {
    logic        v;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ordy;
    logic        fl;
    logic [1:0]  exp_cnt;
    logic        exp_rdy;
  } vec_t;

  entry_t sb[$];
  vec_t   tbl[25];

  alu_result_buffer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_rd(out_rd),
    .out_zero(out_zero), .out_sign(out_sign), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] res, input logic [4:0] rd,
                              input logic ordy, input logic fl, input logic [1:0] c,
                              input logic r);
    vec_t t;
    t.v = v; t.res = res; t.rd = rd; t.ordy = ordy; t.fl = fl; t.exp_cnt = c; t.exp_rdy = r;
    return t;
  endfunction

  // Drive one cycle at the falling edge, check outputs against the scoreboard,
  // then advance the model for the coming rising edge.
  task automatic step(input logic v, input logic [31:0] res, input logic [4:0] rd,
                      input logic ordy, input logic fl);
    logic   exp_rdy;
    entry_t e;
    @(negedge clk);
    in_valid = v; in_res = res; in_rd = rd; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = fl || (sb.size() < 2) || ordy;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("count", {30'd0, count}, sb.size());
    chk("out_valid", {31'd0, out_valid}, {31'd0, (sb.size() != 0)});
    if (sb.size() != 0) begin
      chk("out_res", out_res, sb[0].res);
      chk("out_rd", {27'd0, out_rd}, {27'd0, sb[0].rd});
      chk("out_zero", {31'd0, out_zero}, {31'd0, sb[0].zero});
      chk("out_sign", {31'd0, out_sign}, {31'd0, sb[0].sign});
    end
    if (fl) begin
      sb.delete();
    end else begin
      if (ordy && sb.size() != 0) void'(sb.pop_front());
      if (v && exp_rdy) begin
        e.res = res; e.rd = rd; e.zero = (res == 32'd0); e.sign = res[31];
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_res = 32'd0; in_rd = 5'd0;
    out_ready = 1'b0; flush = 1'b0;

    // Directed table: expected count / in_ready are the values seen before each edge.
    tbl[0]  = mk(1'b1, 32'hA5A5_0000, 5'd3,  1'b1, 1'b0, 2'd0, 1'b1);
    tbl[1]  = mk(1'b0, 32'h0,         5'd0,  1'b1, 1'b0, 2'd1, 1'b1);
    tbl[2]  = mk(1'b0, 32'h0,         5'd0,  1'b1, 1'b0, 2'd0, 1'b1);
    tbl[3]  = mk(1'b1, 32'h0,         5'd1,  1'b0, 1'b0, 2'd0, 1'b1);
    tbl[4]  = mk(1'b1, 32'h1,         5'd2,  1'b0, 1'b0, 2'd1, 1'b1);
    tbl[5]  = mk(1'b1, 32'hDEAD,      5'd4,  1'b0, 1'b0, 2'd2, 1'b0);
    tbl[6]  = mk(1'b1, 32'hBEEF,      5'd5,  1'b0, 1'b0, 2'd2, 1'b0);
    tbl[7]  = mk(1'b0, 32'h0,         5'd0,  1'b1, 1'b0, 2'd2, 1'b1);
    tbl[8]  = mk(1'b0, 32'h0,         5'd0,  1'b1, 1'b0, 2'd1, 1'b1);
    tbl[9]  = mk(1'b0, 32'h0,         5'd0,  1'b0, 1'b0, 2'd0, 1'b1);
    tbl[10] = mk(1'b1, 32'h10,        5'd6,  1'b0, 1'b0, 2'd0, 1'b1);
    tbl[11] = mk(1'b1, 32'h20,        5'd7,  1'b0, 1'b0, 2'd1, 1'b1);
    tbl[12] = mk(1'b1, 32'h7,         5'd8,  1'b1, 1'b0, 2'd2, 1'b1);
    tbl[13] = mk(1'b0, 32'h0,         5'd0,  1'b1, 1'b0, 2'd2, 1'b1);
    tbl[14] = mk(1'b0, 32'h0,         5'd0,  1'b1, 1'b0, 2'd1, 1'b1);
    tbl[15] = mk(1'b0, 32'h0,         5'd0,  1'b0, 1'b0, 2'd0, 1'b1);
    tbl[16] = mk(1'b1, 32'h30,        5'd9,  1'b0, 1'b0, 2'd0, 1'b1);
    tbl[17] = mk(1'b1, 32'h40,        5'd10, 1'b0, 1'b0, 2'd1, 1'b1);
    tbl[18] = mk(1'b1, 32'h55,        5'd11, 1'b0, 1'b1, 2'd2, 1'b1);
    tbl[19] = mk(1'b0, 32'h0,         5'd0,  1'b0, 1'b0, 2'd0, 1'b1);
    tbl[20] = mk(1'b0, 32'h0,         5'd0,  1'b1, 1'b0, 2'd0, 1'b1);
    tbl[21] = mk(1'b0, 32'h0,         5'd0,  1'b1, 1'b0, 2'd0, 1'b1);
    tbl[22] = mk(1'b1, 32'h8000_0000, 5'd0,  1'b1, 1'b0, 2'd0, 1'b1);
    tbl[23] = mk(1'b0, 32'h0,         5'd0,  1'b1, 1'b0, 2'd1, 1'b1);
    tbl[24] = mk(1'b0, 32'h0,         5'd0,  1'b0, 1'b0, 2'd0, 1'b1);

    #12;
    chk("rst_count", {30'd0, count}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_res", out_res, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_out_zero", {31'd0, out_zero}, 32'd1);
    chk("rst_out_sign", {31'd0, out_sign}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      #0;
      @(negedge clk);
      in_valid = tbl[i].v; in_res = tbl[i].res; in_rd = tbl[i].rd;
      out_ready = tbl[i].ordy; flush = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d_count", i), {30'd0, count}, {30'd0, tbl[i].exp_cnt});
      chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].exp_rdy});
      @(posedge clk);
      #1;
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    end

    // Replay the same table through the scoreboard to check head payloads and order.
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 25; i++) begin
      step(tbl[i].v, tbl[i].res, tbl[i].rd, tbl[i].ordy, tbl[i].fl);
    end

    // Async reset between edges with one entry held.
    step(1'b1, 32'h1234_5678, 5'd12, 1'b0, 1'b0);
    step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_reset_count", {30'd0, count}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_count", {30'd0, count}, 32'd0);
    chk("async_out_zero", {31'd0, out_zero}, 32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h0000_0042, 5'd13, 1'b1, 1'b0);
    step(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);

    // Random stream against the scoreboard.
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
      chk("count_bound", {31'd0, (count > 2'd2)}, 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    end
    chk("drained", {30'd0, count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
